// File: rtl/rgb2gray_pkg.sv
// Shared types and constants for the rgb2gray pixel pipeline:
// output mode encoding, register map addresses and default luminosity weights.
package rgb2gray_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_GRAY   = 2'd1,
    MODE_THRESH = 2'd2,
    MODE_INVERT = 2'd3
  } mode_t;

  localparam logic [1:0] ADDR_CTRL = 2'd0;
  localparam logic [1:0] ADDR_RW   = 2'd1;
  localparam logic [1:0] ADDR_GW   = 2'd2;
  localparam logic [1:0] ADDR_BW   = 2'd3;

  localparam int unsigned CTRL_THR_LSB = 8;

  localparam int unsigned DEF_RW = 32'h35;
  localparam int unsigned DEF_GW = 32'hb8;
  localparam int unsigned DEF_BW = 32'h12;

  function automatic mode_t to_mode(input logic [1:0] bits);
    return mode_t'(bits);
  endfunction

endpackage

// File: rtl/rgb2gray_if.sv
// Pixel stream (valid/ready/last) plus register write/read bus of the rgb2gray core.
// slave = core side, master = upstream/downstream/bus side.
interface rgb2gray_if #(
  parameter int unsigned CW = 4
);
  logic            wr_en;
  logic [1:0]      wr_addr;
  logic [31:0]     wr_data;
  logic [1:0]      rd_addr;
  logic [31:0]     rd_data;

  logic [3*CW-1:0] si_data;
  logic            si_valid;
  logic            si_ready;
  logic            si_last;

  logic [3*CW-1:0] so_data;
  logic            so_valid;
  logic            so_ready;
  logic            so_last;

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr,
    input  si_data, si_valid, si_last, so_ready,
    output rd_data, si_ready, so_data, so_valid, so_last
  );

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr,
    output si_data, si_valid, si_last, so_ready,
    input  rd_data, si_ready, so_data, so_valid, so_last
  );
endinterface

// File: rtl/rgb2gray_luma.sv
// Combinational luma: sums the three weighted channel products, rounds to nearest
// and saturates the integer part to CW bits.
module rgb2gray_luma #(
  parameter int unsigned CW = 4,
  parameter int unsigned WW = 8
) (
  input  logic [CW+WW-1:0] p_r,
  input  logic [CW+WW-1:0] p_g,
  input  logic [CW+WW-1:0] p_b,
  output logic [CW-1:0]    y
);
  localparam int unsigned AW = CW + WW + 2;
  localparam logic [AW-1:0] RND = AW'(1) << (WW - 1);

  logic [AW-1:0] sum;
  logic [CW+1:0] y_full;

  always_comb begin
    sum    = AW'(p_r) + AW'(p_g) + AW'(p_b) + RND;
    y_full = (CW + 2)'(sum >> WW);
    // Weights up to ~1.0 each can push the sum past one full-scale channel.
    if (|y_full[CW+1:CW]) begin
      y = '1;
    end else begin
      y = y_full[CW-1:0];
    end
  end

endmodule

// File: rtl/rgb2gray_pipe.sv
// Two-stage streaming colour-to-grayscale core: stage 1 registers the weighted
// products and per-pixel controls, stage 2 registers the mode-selected output pixel.
module rgb2gray_pipe
  import rgb2gray_pkg::*;
#(
  parameter int unsigned CW      = 4,
  parameter int unsigned WW      = 8,
  parameter int unsigned RW_INIT = DEF_RW,
  parameter int unsigned GW_INIT = DEF_GW,
  parameter int unsigned BW_INIT = DEF_BW
) (
  input logic       clk,
  input logic       reset_n,
  rgb2gray_if.slave bus
);
  localparam int unsigned PW = CW + WW;
  localparam int unsigned DW = 3 * CW;
  localparam logic [CW-1:0] THR_INIT = CW'(1 << (CW - 1));

  // Control/weight registers
  mode_t         mode_q, mode_d;
  logic [CW-1:0] thr_q, thr_d;
  logic [WW-1:0] rw_q, rw_d;
  logic [WW-1:0] gw_q, gw_d;
  logic [WW-1:0] bw_q, bw_d;
  logic [31:0]   rd_data;

  // Stage 1
  logic          s1_valid_q, s1_valid_d;
  logic [DW-1:0] s1_pix_q, s1_pix_d;
  logic          s1_last_q, s1_last_d;
  mode_t         s1_mode_q, s1_mode_d;
  logic [CW-1:0] s1_thr_q, s1_thr_d;
  logic [PW-1:0] s1_pr_q, s1_pr_d;
  logic [PW-1:0] s1_pg_q, s1_pg_d;
  logic [PW-1:0] s1_pb_q, s1_pb_d;

  // Stage 2
  logic          so_valid_q, so_valid_d;
  logic [DW-1:0] so_data_q, so_data_d;
  logic          so_last_q, so_last_d;

  logic          advance;
  logic [CW-1:0] in_r, in_g, in_b;
  logic [CW-1:0] y, y_n;
  logic [DW-1:0] out_pix;
  logic          unused_wr_bits;

  assign unused_wr_bits = ^bus.wr_data;

  always_comb begin
    mode_d = mode_q;
    thr_d  = thr_q;
    rw_d   = rw_q;
    gw_d   = gw_q;
    bw_d   = bw_q;
    if (bus.wr_en) begin
      case (bus.wr_addr)
        ADDR_CTRL: begin
          mode_d = to_mode(bus.wr_data[1:0]);
          thr_d  = bus.wr_data[CTRL_THR_LSB +: CW];
        end
        ADDR_RW: rw_d = bus.wr_data[WW-1:0];
        ADDR_GW: gw_d = bus.wr_data[WW-1:0];
        ADDR_BW: bw_d = bus.wr_data[WW-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    case (bus.rd_addr)
      ADDR_CTRL: begin
        rd_data[1:0]                  = mode_q;
        rd_data[CTRL_THR_LSB +: CW]   = thr_q;
      end
      ADDR_RW: rd_data[WW-1:0] = rw_q;
      ADDR_GW: rd_data[WW-1:0] = gw_q;
      ADDR_BW: rd_data[WW-1:0] = bw_q;
      default: ;
    endcase
  end

  assign advance = !so_valid_q || bus.so_ready;
  assign in_r    = bus.si_data[3*CW-1:2*CW];
  assign in_g    = bus.si_data[2*CW-1:CW];
  assign in_b    = bus.si_data[CW-1:0];

  // Stage 1 captures the register values current at acceptance, so a write in
  // the same cycle only affects later pixels.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_pix_d   = s1_pix_q;
    s1_last_d  = s1_last_q;
    s1_mode_d  = s1_mode_q;
    s1_thr_d   = s1_thr_q;
    s1_pr_d    = s1_pr_q;
    s1_pg_d    = s1_pg_q;
    s1_pb_d    = s1_pb_q;
    if (advance) begin
      s1_valid_d = bus.si_valid;
      if (bus.si_valid) begin
        s1_pix_d  = bus.si_data;
        s1_last_d = bus.si_last;
        s1_mode_d = mode_q;
        s1_thr_d  = thr_q;
        s1_pr_d   = PW'(in_r) * PW'(rw_q);
        s1_pg_d   = PW'(in_g) * PW'(gw_q);
        s1_pb_d   = PW'(in_b) * PW'(bw_q);
      end
    end
  end

  rgb2gray_luma #(
    .CW (CW),
    .WW (WW)
  ) u_luma (
    .p_r (s1_pr_q),
    .p_g (s1_pg_q),
    .p_b (s1_pb_q),
    .y   (y)
  );

  always_comb begin
    y_n     = ~y;
    out_pix = s1_pix_q;
    case (s1_mode_q)
      MODE_BYPASS: out_pix = s1_pix_q;
      MODE_GRAY:   out_pix = {y, y, y};
      MODE_THRESH: out_pix = (y >= s1_thr_q) ? '1 : '0;
      MODE_INVERT: out_pix = {y_n, y_n, y_n};
      default:     out_pix = s1_pix_q;
    endcase
  end

  always_comb begin
    so_valid_d = so_valid_q;
    so_data_d  = so_data_q;
    so_last_d  = so_last_q;
    if (advance) begin
      so_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        so_data_d = out_pix;
        so_last_d = s1_last_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q     <= MODE_GRAY;
      thr_q      <= THR_INIT;
      rw_q       <= WW'(RW_INIT);
      gw_q       <= WW'(GW_INIT);
      bw_q       <= WW'(BW_INIT);
      s1_valid_q <= 1'b0;
      s1_pix_q   <= '0;
      s1_last_q  <= 1'b0;
      s1_mode_q  <= MODE_GRAY;
      s1_thr_q   <= '0;
      s1_pr_q    <= '0;
      s1_pg_q    <= '0;
      s1_pb_q    <= '0;
      so_valid_q <= 1'b0;
      so_data_q  <= '0;
      so_last_q  <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      thr_q      <= thr_d;
      rw_q       <= rw_d;
      gw_q       <= gw_d;
      bw_q       <= bw_d;
      s1_valid_q <= s1_valid_d;
      s1_pix_q   <= s1_pix_d;
      s1_last_q  <= s1_last_d;
      s1_mode_q  <= s1_mode_d;
      s1_thr_q   <= s1_thr_d;
      s1_pr_q    <= s1_pr_d;
      s1_pg_q    <= s1_pg_d;
      s1_pb_q    <= s1_pb_d;
      so_valid_q <= so_valid_d;
      so_data_q  <= so_data_d;
      so_last_q  <= so_last_d;
    end
  end

  assign bus.rd_data  = rd_data;
  assign bus.si_ready = advance;
  assign bus.so_data  = so_data_q;
  assign bus.so_valid = so_valid_q;
  assign bus.so_last  = so_last_q;

endmodule

// File: tb/tb_rgb2gray_pipe.sv
// Directed bench for rgb2gray_pipe: a table of single-pixel vectors plus
// back-to-back, write-collision, backpressure and mid-stream reset sequences.
module tb_rgb2gray_pipe;
  import rgb2gray_pkg::*;

  localparam int unsigned CW = 4;
  localparam int unsigned WW = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  rgb2gray_if #(.CW(CW)) bus();

  rgb2gray_pipe #(
    .CW      (CW),
    .WW      (WW),
    .RW_INIT (32'h35),
    .GW_INIT (32'hb8),
    .BW_INIT (32'h12)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [3:0]  thr;
    logic [7:0]  rw;
    logic [7:0]  gw;
    logic [7:0]  bw;
    logic [11:0] pix;
    logic        last;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[15];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] e);
    bus.rd_addr = a;
    #1;
    check(name, bus.rd_data, e);
  endtask

  task automatic send_one(input string nm, input logic [11:0] pix, input logic last,
                          input logic [11:0] exp);
    int lat;
    bus.si_data  = pix;
    bus.si_last  = last;
    bus.si_valid = 1'b1;
    #1;
    check({nm, "_si_ready"}, 32'(bus.si_ready), 32'd1);
    @(negedge clk);
    bus.si_valid = 1'b0;
    bus.si_last  = 1'b0;
    lat = 1;
    while (!bus.so_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({nm, "_valid"}, 32'(bus.so_valid), 32'd1);
    check({nm, "_latency"}, lat, 32'd2);
    check({nm, "_data"}, 32'(bus.so_data), 32'(exp));
    check({nm, "_last"}, 32'(bus.so_last), 32'(last));
    @(negedge clk);
  endtask

  logic [11:0] bb_in[4]  = '{12'hFFF, 12'h000, 12'h0F0, 12'hF00};
  logic [11:0] bb_exp[4] = '{12'hFFF, 12'h000, 12'hBBB, 12'h333};
  logic [11:0] bp_in[8]  = '{12'hFFF, 12'h000, 12'h0F0, 12'hF00,
                             12'h00F, 12'h0FF, 12'hF0F, 12'hFF0};
  logic [11:0] bp_exp[8] = '{12'hFFF, 12'h000, 12'hBBB, 12'h333,
                             12'h111, 12'hCCC, 12'h444, 12'hEEE};

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int in_idx, out_idx, cyc;
    logic prev_stall;
    logic [11:0] prev_data;

    vecs[0]  = '{2'd1, 4'd8, 8'h35, 8'hb8, 8'h12, 12'hFFF, 1'b0, 12'hFFF};
    vecs[1]  = '{2'd1, 4'd8, 8'h35, 8'hb8, 8'h12, 12'h000, 1'b1, 12'h000};
    vecs[2]  = '{2'd1, 4'd8, 8'h35, 8'hb8, 8'h12, 12'h0F0, 1'b0, 12'hBBB};
    vecs[3]  = '{2'd1, 4'd8, 8'h35, 8'hb8, 8'h12, 12'hF00, 1'b1, 12'h333};
    vecs[4]  = '{2'd1, 4'd8, 8'hFF, 8'hFF, 8'hFF, 12'hFFF, 1'b0, 12'hFFF};
    vecs[5]  = '{2'd2, 4'd8, 8'h35, 8'hb8, 8'h12, 12'h0F0, 1'b0, 12'hFFF};
    vecs[6]  = '{2'd2, 4'd8, 8'h35, 8'hb8, 8'h12, 12'hF00, 1'b1, 12'h000};
    vecs[7]  = '{2'd3, 4'd8, 8'h35, 8'hb8, 8'h12, 12'h0F0, 1'b0, 12'h444};
    vecs[8]  = '{2'd0, 4'd8, 8'h35, 8'hb8, 8'h12, 12'hA5C, 1'b1, 12'hA5C};
    vecs[9]  = '{2'd1, 4'd8, 8'h35, 8'hb8, 8'h12, 12'h00F, 1'b0, 12'h111};
    vecs[10] = '{2'd2, 4'd3, 8'h35, 8'hb8, 8'h12, 12'hF00, 1'b0, 12'hFFF};
    vecs[11] = '{2'd2, 4'd4, 8'h35, 8'hb8, 8'h12, 12'hF00, 1'b0, 12'h000};
    vecs[12] = '{2'd3, 4'd8, 8'h35, 8'hb8, 8'h12, 12'h000, 1'b1, 12'hFFF};
    vecs[13] = '{2'd1, 4'd8, 8'h80, 8'h00, 8'h00, 12'h100, 1'b0, 12'h111};
    vecs[14] = '{2'd1, 4'd8, 8'h7F, 8'h00, 8'h00, 12'h100, 1'b0, 12'h000};

    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rd_addr  = '0;
    bus.si_data  = '0;
    bus.si_valid = 1'b0;
    bus.si_last  = 1'b0;
    bus.so_ready = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_so_valid", 32'(bus.so_valid), 32'd0);
    check("rst_so_data", 32'(bus.so_data), 32'd0);
    check("rst_so_last", 32'(bus.so_last), 32'd0);
    rd_chk("rst_ctrl", ADDR_CTRL, 32'h801);
    rd_chk("rst_rw", ADDR_RW, 32'h35);
    rd_chk("rst_gw", ADDR_GW, 32'hb8);
    rd_chk("rst_bw", ADDR_BW, 32'h12);
    reset_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      wr_reg(ADDR_CTRL, {20'd0, vecs[i].thr, 6'd0, vecs[i].mode});
      wr_reg(ADDR_RW, {24'd0, vecs[i].rw});
      wr_reg(ADDR_GW, {24'd0, vecs[i].gw});
      wr_reg(ADDR_BW, {24'd0, vecs[i].bw});
      send_one($sformatf("vec%0d", i), vecs[i].pix, vecs[i].last, vecs[i].exp);
    end

    wr_reg(ADDR_CTRL, 32'h801);
    wr_reg(ADDR_RW, 32'h35);
    wr_reg(ADDR_GW, 32'hb8);
    wr_reg(ADDR_BW, 32'h12);
    rd_chk("rd_ctrl_restored", ADDR_CTRL, 32'h801);

    // Back-to-back stream: one result per cycle, two cycles after each input.
    @(negedge clk);
    for (int c = 0; c < 8; c++) begin
      if (c >= 2 && c < 6) begin
        check($sformatf("bb%0d_valid", c), 32'(bus.so_valid), 32'd1);
        check($sformatf("bb%0d_data", c), 32'(bus.so_data), 32'(bb_exp[c-2]));
      end else begin
        check($sformatf("bb%0d_idle", c), 32'(bus.so_valid), 32'd0);
      end
      if (c < 4) begin
        bus.si_valid = 1'b1;
        bus.si_data  = bb_in[c];
      end else begin
        bus.si_valid = 1'b0;
      end
      @(negedge clk);
    end

    // Register write in the same cycle as an accept: that pixel sees the old mode.
    bus.si_valid = 1'b1;
    bus.si_data  = 12'h0F0;
    bus.wr_en    = 1'b1;
    bus.wr_addr  = ADDR_CTRL;
    bus.wr_data  = 32'h803;
    @(negedge clk);
    bus.wr_en    = 1'b0;
    @(negedge clk);
    bus.si_valid = 1'b0;
    check("wc_old_valid", 32'(bus.so_valid), 32'd1);
    check("wc_old_data", 32'(bus.so_data), 32'hBBB);
    @(negedge clk);
    check("wc_new_valid", 32'(bus.so_valid), 32'd1);
    check("wc_new_data", 32'(bus.so_data), 32'h444);
    @(negedge clk);
    wr_reg(ADDR_CTRL, 32'h801);

    // Random backpressure on 8 pixels.
    in_idx = 0;
    out_idx = 0;
    cyc = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    while (out_idx < 8 && cyc < 300) begin
      bus.so_ready = 1'($urandom_range(0, 1));
      if (in_idx < 8) begin
        bus.si_valid = 1'b1;
        bus.si_data  = bp_in[in_idx];
        bus.si_last  = (in_idx == 7);
      end else begin
        bus.si_valid = 1'b0;
        bus.si_last  = 1'b0;
      end
      #1;
      if (prev_stall) begin
        check("bp_hold_valid", 32'(bus.so_valid), 32'd1);
        check("bp_hold_data", 32'(bus.so_data), 32'(prev_data));
      end
      if (bus.so_valid && !bus.so_ready)
        check("bp_si_ready", 32'(bus.si_ready), 32'd0);
      if (bus.so_valid && bus.so_ready) begin
        check($sformatf("bp%0d_data", out_idx), 32'(bus.so_data), 32'(bp_exp[out_idx]));
        check($sformatf("bp%0d_last", out_idx), 32'(bus.so_last), 32'(out_idx == 7));
        out_idx++;
      end
      if (bus.si_valid && bus.si_ready) in_idx++;
      prev_stall = bus.so_valid && !bus.so_ready;
      prev_data  = bus.so_data;
      @(negedge clk);
      cyc++;
    end
    check("bp_count", out_idx, 32'd8);
    bus.so_ready = 1'b1;
    bus.si_valid = 1'b0;
    bus.si_last  = 1'b0;
    @(negedge clk);

    // Reset with two pixels in flight and non-default registers.
    wr_reg(ADDR_CTRL, 32'h303);
    wr_reg(ADDR_RW, 32'h10);
    bus.si_valid = 1'b1;
    bus.si_data  = 12'h0F0;
    @(negedge clk);
    @(negedge clk);
    bus.si_valid = 1'b0;
    #1;
    check("rs_inflight_valid", 32'(bus.so_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rs_async_valid", 32'(bus.so_valid), 32'd0);
    check("rs_async_data", 32'(bus.so_data), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    rd_chk("rs_ctrl", ADDR_CTRL, 32'h801);
    rd_chk("rs_rw", ADDR_RW, 32'h35);
    @(negedge clk);
    send_one("rs_next", 12'h0F0, 1'b1, 12'hBBB);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
